// File: rtl/uart_pkg.sv
// Shared definitions for the monitor UART transmit path: FSM state encoding and frame constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int         UART_DBITS    = 8;
  localparam logic [2:0] UART_BIT_LAST = 3'd7;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers; writes on full and reads on empty are ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  logic [7:0] mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        wr_ok;
  logic        rd_ok;

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign wr_ok = wr && !full;
  assign rd_ok = rd && !empty;
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: contents are meaningless once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: FIFO-buffered bytes serialised as 8N1 frames paced by the shared baud timer.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1, 11 bit periods per frame).
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_wr,
  input  logic [7:0] tx_wdata,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_busy,
  output logic       tx_ovf,
  input  logic       tx_ovf_clr,
  output logic       uart_tm_en,
  input  logic       uart_tm_ov,
  output logic       txd
);

  uart_state_t           state, state_n;
  logic [UART_DBITS-1:0] shreg, shreg_n;
  logic [2:0]            bit_cnt, bit_cnt_n;
  logic                  txd_n;
  logic                  tm_en_n;
  logic                  pop;
  logic [7:0]            fifo_dout;
`ifdef UART_TX_PARITY_EN
  logic                  par, par_n;
`endif

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (tx_wr),
    .rd    (pop),
    .din   (tx_wdata),
    .dout  (fifo_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign tx_busy = (state != ST_IDLE);

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    txd_n     = txd;
    tm_en_n   = uart_tm_en;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n     = par;
`endif
    case (state)
      ST_IDLE: begin
        if (!tx_empty) begin
          pop     = 1'b1;
          shreg_n = fifo_dout;
          txd_n   = 1'b0;
          tm_en_n = 1'b1;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (uart_tm_ov) begin
          txd_n     = shreg[0];
          bit_cnt_n = '0;
`ifdef UART_TX_PARITY_EN
          par_n     = shreg[0];
`endif
          state_n   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (uart_tm_ov) begin
          if (bit_cnt == UART_BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            txd_n   = par;
            state_n = ST_PARITY;
`else
            txd_n   = 1'b1;
            state_n = ST_STOP;
`endif
          end else begin
            shreg_n   = shreg >> 1;
            txd_n     = shreg[1];
            bit_cnt_n = bit_cnt + 3'd1;
`ifdef UART_TX_PARITY_EN
            par_n     = par ^ shreg[1];
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (uart_tm_ov) begin
          txd_n   = 1'b1;
          state_n = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Chain straight into the next start bit so queued frames have no idle gap.
        if (uart_tm_ov) begin
          if (!tx_empty) begin
            pop     = 1'b1;
            shreg_n = fifo_dout;
            txd_n   = 1'b0;
            state_n = ST_START;
          end else begin
            txd_n   = 1'b1;
            tm_en_n = 1'b0;
            state_n = ST_IDLE;
          end
        end
      end
      default: begin
        txd_n   = 1'b1;
        tm_en_n = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      txd        <= 1'b1;
      uart_tm_en <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      txd        <= txd_n;
      uart_tm_en <= tm_en_n;
`ifdef UART_TX_PARITY_EN
      par        <= par_n;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_ovf <= 1'b0;
    end else if (tx_wr && tx_full) begin
      tx_ovf <= 1'b1;
    end else if (tx_ovf_clr) begin
      tx_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: baud timer model, frame decoder and FIFO capacity model.
module tb_uart_tx_ctrl;

  localparam int BIT_CYC = 135;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = BIT_CYC * FRAME_BITS;
  localparam int DEPTH     = 4;

  logic       clk;
  logic       rst;
  logic       tx_wr;
  logic [7:0] tx_wdata;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_busy;
  logic       tx_ovf;
  logic       tx_ovf_clr;
  logic       uart_tm_en;
  logic       uart_tm_ov;
  logic       txd;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_ctrl #(.FIFO_DEPTH(DEPTH), .FIFO_AW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_wr      (tx_wr),
    .tx_wdata   (tx_wdata),
    .tx_full    (tx_full),
    .tx_empty   (tx_empty),
    .tx_busy    (tx_busy),
    .tx_ovf     (tx_ovf),
    .tx_ovf_clr (tx_ovf_clr),
    .uart_tm_en (uart_tm_en),
    .uart_tm_ov (uart_tm_ov),
    .txd        (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud timer: counts while enabled, held at zero otherwise, pulses on the last cycle of a period.
  int   tm_cnt;
  logic ov_inj;
  always @(posedge clk or posedge rst) begin
    if (rst) tm_cnt <= 0;
    else if (!uart_tm_en || tm_cnt == BIT_CYC - 1) tm_cnt <= 0;
    else tm_cnt <= tm_cnt + 1;
  end
  assign uart_tm_ov = (uart_tm_en && tm_cnt == BIT_CYC - 1) || ov_inj;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame decoder: samples mid-bit and compares with the next byte the model says was accepted.
  logic [7:0] exp_q[$];
  logic       mon_en;
  logic [7:0] mon_b;
  initial begin
    mon_b = 8'h00;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && txd === 1'b0) begin
        chk("frame_expected", exp_q.size() > 0, 1);
        mon_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        repeat (BIT_CYC / 2) @(negedge clk);
        chk("start_bit", txd, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CYC) @(negedge clk);
          chk("data_bit", txd, mon_b[i]);
        end
`ifdef UART_TX_PARITY_EN
        repeat (BIT_CYC) @(negedge clk);
        chk("parity_bit", txd, ^mon_b);
`endif
        repeat (BIT_CYC) @(negedge clk);
        chk("stop_bit", txd, 1);
      end
    end
  end

  // Writes k bytes on consecutive cycles; room is how many the FIFO can still take in this burst.
  task automatic burst(input int k, input bit from_idle, input logic [7:0] first);
    int occ;
    int room;
    room = from_idle ? DEPTH + 1 : DEPTH;
    for (int i = 1; i <= k; i++) begin
      tx_wr    = 1'b1;
      tx_wdata = (i == 1) ? first : 8'($urandom_range(0, 255));
      if (i <= room) exp_q.push_back(tx_wdata);
      @(negedge clk);
      if (from_idle) occ = (i == 1) ? 1 : ((i - 1 > DEPTH) ? DEPTH : i - 1);
      else occ = (i > DEPTH) ? DEPTH : i;
      chk("full_level", tx_full, occ == DEPTH);
      chk("ovf_level", tx_ovf, i > room);
    end
    tx_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while ((tx_busy || uart_tm_en) && n < 8 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    chk("idle_in_time", n < 8 * FRAME_CYC, 1);
    chk("all_frames_sent", exp_q.size(), 0);
    chk("idle_empty", tx_empty, 1);
    chk("idle_txd", txd, 1);
  endtask

  task automatic measure_en(output int lat, output int hi);
    lat = 0;
    hi  = 0;
    while (!uart_tm_en && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    while (uart_tm_en && hi < 8 * FRAME_CYC) begin
      @(negedge clk);
      hi++;
    end
  endtask

  int lat;
  int hi;
  int k;
  bit idle_mode;

  initial begin
    rst        = 1'b1;
    tx_wr      = 1'b0;
    tx_wdata   = 8'h00;
    tx_ovf_clr = 1'b0;
    ov_inj     = 1'b0;
    mon_en     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_tm_en", uart_tm_en, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_full", tx_full, 0);
    chk("rst_empty", tx_empty, 1);
    chk("rst_ovf", tx_ovf, 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Single 0x55 frame: start latency, enable window and busy alignment.
    burst(1, 1'b1, 8'h55);
    measure_en(lat, hi);
    chk("start_latency", lat, 1);
    chk("single_frame_cycles", hi, FRAME_CYC);
    chk("busy_falls_with_en", tx_busy, 0);
    wait_idle();

    // Back-to-back frames keep the enable high for exactly two frames.
    burst(2, 1'b1, 8'hA3);
    measure_en(lat, hi);
    chk("b2b_cycles", hi, 2 * FRAME_CYC);
    wait_idle();

    // Overflow while a frame is active; set wins over clear.
    burst(1, 1'b1, 8'($urandom_range(0, 255)));
    repeat (20) @(negedge clk);
    burst(DEPTH + 1, 1'b0, 8'($urandom_range(0, 255)));
    tx_wr      = 1'b1;
    tx_ovf_clr = 1'b1;
    @(negedge clk);
    tx_wr      = 1'b0;
    chk("ovf_set_beats_clr", tx_ovf, 1);
    @(negedge clk);
    tx_ovf_clr = 1'b0;
    chk("ovf_cleared", tx_ovf, 0);
    wait_idle();

    // Randomized bursts from idle or during an active frame.
    for (int it = 0; it < 5; it++) begin
      idle_mode = 1'($urandom_range(0, 1));
      k = $urandom_range(1, 6);
      if (!idle_mode) begin
        burst(1, 1'b1, 8'($urandom_range(0, 255)));
        repeat ($urandom_range(5, 200)) @(negedge clk);
        if (k > DEPTH + 1) k = DEPTH + 1;
      end
      burst(k, idle_mode, 8'($urandom_range(0, 255)));
      tx_ovf_clr = 1'b1;
      @(negedge clk);
      tx_ovf_clr = 1'b0;
      chk("rand_ovf_clr", tx_ovf, 0);
      wait_idle();
    end

    // Reset in the middle of a 0xFF data phase.
    mon_en = 1'b0;
    burst(1, 1'b1, 8'hFF);
    exp_q.delete();
    repeat (3 * BIT_CYC) @(negedge clk);
    chk("pre_rst_busy", tx_busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_txd", txd, 1);
    chk("midrst_tm_en", uart_tm_en, 0);
    chk("midrst_empty", tx_empty, 1);
    chk("midrst_busy", tx_busy, 0);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    burst(1, 1'b1, 8'($urandom_range(0, 255)));
    measure_en(lat, hi);
    chk("post_rst_frame_cycles", hi, FRAME_CYC);
    wait_idle();

    // Timer pulses while idle are ignored.
    for (int i = 0; i < 3; i++) begin
      ov_inj = 1'b1;
      @(negedge clk);
      ov_inj = 1'b0;
      @(negedge clk);
      chk("idle_ov_txd", txd, 1);
      chk("idle_ov_busy", tx_busy, 0);
      chk("idle_ov_tm_en", uart_tm_en, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit controller for the monitor UART path. It buffers bytes from the monitor core in a small FIFO and serialises them onto txd as 8N1 frames, LSB first. It sequences the shared baud timer through uart_tm_en / uart_tm_ov, with one timer period per bit. It sits between the monitor command logic and the baud timer / pad.

Parameters:
- FIFO_DEPTH, 4: TX FIFO entries; must be a power of two, 2..16.
- FIFO_AW, 2: FIFO address width, log2(FIFO_DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- tx_wr  in  1  write strobe; one byte per cycle when high
- tx_wdata  in  8  byte to transmit
- tx_full  out  1  FIFO full; a write while high is dropped
- tx_empty  out  1  FIFO empty
- tx_busy  out  1  frame in progress (state != IDLE)
- tx_ovf  out  1  sticky: a write was dropped; cleared by tx_ovf_clr
- tx_ovf_clr  in  1  clears tx_ovf
- uart_tm_en  out  1  baud timer enable; low holds the timer at zero
- uart_tm_ov  in  1  one-cycle pulse at the end of each bit period while uart_tm_en is high
- txd  out  1  serial output, idle high

Behaviour:
- Reset values: txd=1, uart_tm_en=0, tx_busy=0, tx_full=0, tx_empty=1, tx_ovf=0, FIFO pointers=0, state IDLE.
- FIFO: registered pointers with an extra wrap bit.
  - full when the pointers differ only in the MSB; empty when they are equal.
  - A write on full is dropped and sets tx_ovf, even if a pop occurs in the same cycle.
  - A write and a pop in the same cycle on a non-full FIFO are both performed.
  - A write to an empty FIFO does not start a frame in the same cycle; the frame starts the following cycle.
- tx_ovf: set has priority over tx_ovf_clr when both occur in one cycle.
- State machine:
  - IDLE: if !tx_empty, pop the head into shreg[7:0]; next cycle txd=0, uart_tm_en=1, go to START.
  - START: on uart_tm_ov: txd=shreg[0], bit_cnt=0, go to DATA.
  - DATA: on uart_tm_ov:
    - if bit_cnt==7: txd=1, go to STOP (PARITY when enabled).
    - otherwise: shift shreg right, txd=next bit, bit_cnt+1.
  - STOP: on uart_tm_ov:
    - if !tx_empty: pop, txd=0, go to START with uart_tm_en held high (back-to-back frames, no idle bit).
    - otherwise: uart_tm_en=0, txd=1, go to IDLE.
- Bit timing: every bit lasts exactly one timer period. The timer self-clears on overflow, so uart_tm_en stays high across bit boundaries.
- bit_cnt is 3 bits and never wraps outside DATA.
- txd and uart_tm_en are registered outputs; txd changes on the same edge that samples uart_tm_ov.
- uart_tm_ov while uart_tm_en=0 (IDLE) is ignored.
- Reset mid-frame: immediate return to reset values; FIFO contents are discarded.

Optional Feature:
UART_TX_PARITY_EN
- Defined:
  - adds state PARITY between DATA and STOP; parity bit is the even parity of the byte (XOR of the 8 data bits), accumulated during DATA.
  - DATA bit 7 transitions to PARITY, driving the parity bit; PARITY on uart_tm_ov drives txd=1 and goes to STOP.
  - frame length is 11 bit periods.
- Undefined: 8N1 only, frame length 10 bit periods; no parity register is synthesised.

Decomposition:
- Shared package uart_pkg: state encoding constants (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, 3-bit), UART_DBITS=8, UART_BIT_LAST=3'd7.
- One natural sub-module: uart_tx_fifo (parameterised synchronous FIFO: wr, rd, din, dout, full, empty). The FSM and shifter stay in the top level.

Test Plan:
- Timer model pulses uart_tm_ov every 135 cycles while en=1; write 0x55 -> txd reads 0,1,0,1,0,1,0,1,0,1, each level held 135 cycles; uart_tm_en high for 1350 cycles, then low; tx_busy falls with it.
- Write 0xA3 then 0x0F on consecutive cycles -> two frames back-to-back, no idle gap; uart_tm_en never drops between frames; second start bit begins on the stop-bit ov edge.
- Write FIFO_DEPTH+1 bytes on consecutive cycles starting while a frame is active (4 entries free) -> tx_full after the 4th write; 5th dropped; tx_ovf=1; tx_ovf_clr clears it; the 4 accepted bytes are sent in order.
- Assert rst mid-DATA of 0xFF -> next edge txd=1, uart_tm_en=0, tx_empty=1; a byte written after reset transmits correctly.
- Inject uart_tm_ov pulses while IDLE -> no txd change, state stays IDLE.
- With UART_TX_PARITY_EN, send 0x07 -> parity bit 1 (three ones), then stop; 11-bit frame = 1485 cycles.
